// File: rtl/rob_pkg.sv
// Shared types and constants for the reorder buffer / commit stage.
package rob_pkg;

    localparam int ROB_WIDTH = 6;
    localparam int ROB_DEPTH = 2 ** ROB_WIDTH;
    localparam int REG_WIDTH = 6;

    typedef struct packed {
        logic                 valid;
        logic                 done;
        logic                 regdest;
        logic                 memread;
        logic                 taken;
        logic [REG_WIDTH-1:0] wreg;
        logic [31:0]          pc;
        logic [31:0]          data;
        logic [31:0]          target;
    } rob_entry_t;

endpackage

// File: rtl/rob_commit_if.sv
// Dispatch/EXE-facing bus of the ROB: allocation, completion, commit forwarding and flush.
interface rob_commit_if #(
    parameter int ROBWIDTH = rob_pkg::ROB_WIDTH
);

    logic                          Alloc_Valid_IN;
    logic [rob_pkg::REG_WIDTH-1:0] Alloc_writeRegister_IN;
    logic [31:0]                   Alloc_PC_IN;
    logic [ROBWIDTH-1:0]           ROBTail_OUT;
    logic                          ROB_Full_OUT;
    logic                          ROB_Empty_OUT;

    logic                          Complete_Valid_IN;
    logic [ROBWIDTH-1:0]           Complete_ROBPointer_IN;
    logic [31:0]                   Complete_Data_IN;
    logic                          Complete_RegDest_IN;
    logic                          Complete_MemRead_IN;
    logic                          Complete_Branch_flag_IN;
    logic [31:0]                   Complete_target_PC_IN;

    logic [31:0]                   fwd_data_1_COM;
    logic [rob_pkg::REG_WIDTH-1:0] fwd_reg_1_COM;
    logic                          fwd_data_1_COM_flag;
    logic [31:0]                   LS_fwd_data_COM;
    logic [rob_pkg::REG_WIDTH-1:0] LS_fwd_reg_COM;
    logic                          LS_fwd_data_COM_flag;
    logic                          Flush_OUT;
    logic [31:0]                   Flush_PC_OUT;
    logic                          ROB_Error_OUT;

    modport master (
        output Alloc_Valid_IN, Alloc_writeRegister_IN, Alloc_PC_IN,
        output Complete_Valid_IN, Complete_ROBPointer_IN, Complete_Data_IN,
        output Complete_RegDest_IN, Complete_MemRead_IN, Complete_Branch_flag_IN,
        output Complete_target_PC_IN,
        input  ROBTail_OUT, ROB_Full_OUT, ROB_Empty_OUT,
        input  fwd_data_1_COM, fwd_reg_1_COM, fwd_data_1_COM_flag,
        input  LS_fwd_data_COM, LS_fwd_reg_COM, LS_fwd_data_COM_flag,
        input  Flush_OUT, Flush_PC_OUT, ROB_Error_OUT
    );

    modport slave (
        input  Alloc_Valid_IN, Alloc_writeRegister_IN, Alloc_PC_IN,
        input  Complete_Valid_IN, Complete_ROBPointer_IN, Complete_Data_IN,
        input  Complete_RegDest_IN, Complete_MemRead_IN, Complete_Branch_flag_IN,
        input  Complete_target_PC_IN,
        output ROBTail_OUT, ROB_Full_OUT, ROB_Empty_OUT,
        output fwd_data_1_COM, fwd_reg_1_COM, fwd_data_1_COM_flag,
        output LS_fwd_data_COM, LS_fwd_reg_COM, LS_fwd_data_COM_flag,
        output Flush_OUT, Flush_PC_OUT, ROB_Error_OUT
    );

endinterface

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the ROB; pointers wrap naturally at 2**ROBWIDTH.
module rob_ptr_ctrl #(
    parameter int ROBWIDTH = 6
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                alloc_fire,
    input  logic                commit_fire,
    input  logic                flush,
    output logic [ROBWIDTH-1:0] head,
    output logic [ROBWIDTH-1:0] tail,
    output logic                full,
    output logic                empty
);

    localparam logic [ROBWIDTH:0] CNT_ONE  = (ROBWIDTH+1)'(1);
    localparam logic [ROBWIDTH:0] CNT_FULL = CNT_ONE << ROBWIDTH;

    logic [ROBWIDTH:0] count;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc_fire)
                tail <= tail + ROBWIDTH'(1);
            if (commit_fire)
                head <= head + ROBWIDTH'(1);
            if (alloc_fire && !commit_fire)
                count <= count + CNT_ONE;
            else if (!alloc_fire && commit_fire)
                count <= count - CNT_ONE;
        end
    end

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer with in-order single-wide commit, COM forwarding buses and taken-branch flush.
// Define ROB_CHECK_EN to build the sticky protocol-error detector behind ROB_Error_OUT.
module rob_commit
    import rob_pkg::*;
#(
    parameter int ROBWIDTH = ROB_WIDTH
) (
    input logic         CLK,
    input logic         RESET,
    input logic         FREEZE,
    rob_commit_if.slave bus
);

    localparam int DEPTH = 2 ** ROBWIDTH;

    rob_entry_t          entry_q [DEPTH];
    logic [ROBWIDTH-1:0] head;
    logic [ROBWIDTH-1:0] tail;
    logic                full;
    logic                empty;

    logic commit_fire;
    logic flush_now;
    logic alloc_fire;
    logic complete_fire;
    logic unused_pc;

    // Commit decisions use only registered entry state, so a same-cycle completion waits a cycle.
    assign commit_fire   = !FREEZE && entry_q[head].valid && entry_q[head].done;
    assign flush_now     = commit_fire && entry_q[head].taken;
    assign alloc_fire    = bus.Alloc_Valid_IN && !full && !FREEZE && !flush_now;
    assign complete_fire = bus.Complete_Valid_IN && !FREEZE && !flush_now
                           && entry_q[bus.Complete_ROBPointer_IN].valid;
    assign unused_pc     = ^entry_q[head].pc;

    rob_ptr_ctrl #(.ROBWIDTH(ROBWIDTH)) u_ptr (
        .CLK         (CLK),
        .RESET       (RESET),
        .alloc_fire  (alloc_fire),
        .commit_fire (commit_fire),
        .flush       (flush_now),
        .head        (head),
        .tail        (tail),
        .full        (full),
        .empty       (empty)
    );

    assign bus.ROBTail_OUT   = tail;
    assign bus.ROB_Full_OUT  = full;
    assign bus.ROB_Empty_OUT = empty;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++)
                entry_q[i] <= '0;
        end else if (flush_now) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i].valid <= 1'b0;
                entry_q[i].done  <= 1'b0;
            end
        end else begin
            if (alloc_fire)
                entry_q[tail] <= '{valid: 1'b1, done: 1'b0, regdest: 1'b0, memread: 1'b0,
                                   taken: 1'b0, wreg: bus.Alloc_writeRegister_IN,
                                   pc: bus.Alloc_PC_IN, data: '0, target: '0};
            if (complete_fire) begin
                entry_q[bus.Complete_ROBPointer_IN].done    <= 1'b1;
                entry_q[bus.Complete_ROBPointer_IN].data    <= bus.Complete_Data_IN;
                entry_q[bus.Complete_ROBPointer_IN].regdest <= bus.Complete_RegDest_IN;
                entry_q[bus.Complete_ROBPointer_IN].memread <= bus.Complete_MemRead_IN;
                entry_q[bus.Complete_ROBPointer_IN].taken   <= bus.Complete_Branch_flag_IN;
                entry_q[bus.Complete_ROBPointer_IN].target  <= bus.Complete_target_PC_IN;
            end
            // Retiring entry is cleared last so it wins over a late completion to the head.
            if (commit_fire)
                entry_q[head] <= '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            bus.fwd_data_1_COM       <= '0;
            bus.fwd_reg_1_COM        <= '0;
            bus.fwd_data_1_COM_flag  <= 1'b0;
            bus.LS_fwd_data_COM      <= '0;
            bus.LS_fwd_reg_COM       <= '0;
            bus.LS_fwd_data_COM_flag <= 1'b0;
            bus.Flush_OUT            <= 1'b0;
            bus.Flush_PC_OUT         <= '0;
        end else begin
            bus.fwd_data_1_COM_flag  <= commit_fire && entry_q[head].regdest;
            bus.LS_fwd_data_COM_flag <= commit_fire && entry_q[head].memread;
            bus.Flush_OUT            <= flush_now;
            if (commit_fire && entry_q[head].regdest) begin
                bus.fwd_data_1_COM <= entry_q[head].data;
                bus.fwd_reg_1_COM  <= entry_q[head].wreg;
            end
            if (commit_fire && entry_q[head].memread) begin
                bus.LS_fwd_data_COM <= entry_q[head].data;
                bus.LS_fwd_reg_COM  <= entry_q[head].wreg;
            end
            if (flush_now)
                bus.Flush_PC_OUT <= entry_q[head].target;
        end
    end

`ifdef ROB_CHECK_EN
    logic err_q;
    logic err_evt;

    assign err_evt = !FREEZE && (
                         (bus.Alloc_Valid_IN && full) ||
                         (bus.Complete_Valid_IN && !flush_now &&
                          (!entry_q[bus.Complete_ROBPointer_IN].valid ||
                           entry_q[bus.Complete_ROBPointer_IN].done ||
                           (bus.Complete_RegDest_IN && bus.Complete_MemRead_IN))));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            err_q <= 1'b0;
        else if (err_evt)
            err_q <= 1'b1;
    end

    assign bus.ROB_Error_OUT = err_q;
`else
    assign bus.ROB_Error_OUT = 1'b0;
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Directed plus random bench for rob_commit against an in-order queue reference model.
module tb_rob_commit;
    import rob_pkg::*;

    typedef struct {
        int          tag;
        logic [5:0]  wreg;
        bit          done;
        bit          rd;
        bit          mr;
        bit          tk;
        logic [31:0] data;
        logic [31:0] tgt;
    } ment_t;

    logic CLK    = 1'b0;
    logic RESET  = 1'b0;
    logic FREEZE = 1'b0;

    rob_commit_if bus ();

    rob_commit #(.ROBWIDTH(ROB_WIDTH)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .FREEZE (FREEZE),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    ment_t       mq[$];
    int          m_tail;
    bit          m_fwd_f, m_ls_f, m_fl, m_err;
    logic [31:0] m_fwd_d, m_ls_d, m_fl_pc;
    logic [5:0]  m_fwd_r, m_ls_r;
    int          n_assert = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("full",      32'(bus.ROB_Full_OUT),         32'(mq.size() == ROB_DEPTH));
        chk("empty",     32'(bus.ROB_Empty_OUT),        32'(mq.size() == 0));
        chk("tail",      32'(bus.ROBTail_OUT),          32'(m_tail));
        chk("fwd_flag",  32'(bus.fwd_data_1_COM_flag),  32'(m_fwd_f));
        chk("fwd_data",  bus.fwd_data_1_COM,            m_fwd_d);
        chk("fwd_reg",   32'(bus.fwd_reg_1_COM),        32'(m_fwd_r));
        chk("ls_flag",   32'(bus.LS_fwd_data_COM_flag), 32'(m_ls_f));
        chk("ls_data",   bus.LS_fwd_data_COM,           m_ls_d);
        chk("ls_reg",    32'(bus.LS_fwd_reg_COM),       32'(m_ls_r));
        chk("flush",     32'(bus.Flush_OUT),            32'(m_fl));
        chk("flush_pc",  bus.Flush_PC_OUT,              m_fl_pc);
        chk("error",     32'(bus.ROB_Error_OUT),        32'(m_err));
    endtask

    task automatic clr_in();
        FREEZE                      = 1'b0;
        bus.Alloc_Valid_IN          = 1'b0;
        bus.Alloc_writeRegister_IN  = '0;
        bus.Alloc_PC_IN             = '0;
        bus.Complete_Valid_IN       = 1'b0;
        bus.Complete_ROBPointer_IN  = '0;
        bus.Complete_Data_IN        = '0;
        bus.Complete_RegDest_IN     = 1'b0;
        bus.Complete_MemRead_IN     = 1'b0;
        bus.Complete_Branch_flag_IN = 1'b0;
        bus.Complete_target_PC_IN   = '0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_tail  = 0;
        m_fwd_f = 0; m_ls_f = 0; m_fl = 0; m_err = 0;
        m_fwd_d = '0; m_ls_d = '0; m_fl_pc = '0;
        m_fwd_r = '0; m_ls_r = '0;
    endtask

    // One clock: predict from the queue model, clock the DUT, compare everything.
    task automatic cycle();
        bit    frz, av, cv, com, fl;
        int    sz, idx;
        ment_t h;
        ment_t e;
        frz = FREEZE;
        av  = bus.Alloc_Valid_IN;
        cv  = bus.Complete_Valid_IN;
        sz  = mq.size();
        com = !frz && sz > 0 && mq[0].done;
        if (com) h = mq[0];
        fl  = com && h.tk;
        idx = -1;
        foreach (mq[i])
            if (mq[i].tag == int'(bus.Complete_ROBPointer_IN)) idx = i;
`ifdef ROB_CHECK_EN
        if (!frz && av && sz == ROB_DEPTH) m_err = 1;
        if (!frz && cv && !fl && (idx < 0 || mq[idx].done ||
            (bus.Complete_RegDest_IN && bus.Complete_MemRead_IN))) m_err = 1;
`endif
        if (!frz && cv && !fl && idx >= 0) begin
            mq[idx].done = 1;
            mq[idx].data = bus.Complete_Data_IN;
            mq[idx].rd   = bus.Complete_RegDest_IN;
            mq[idx].mr   = bus.Complete_MemRead_IN;
            mq[idx].tk   = bus.Complete_Branch_flag_IN;
            mq[idx].tgt  = bus.Complete_target_PC_IN;
        end
        m_fwd_f = com && h.rd;
        if (m_fwd_f) begin m_fwd_d = h.data; m_fwd_r = h.wreg; end
        m_ls_f = com && h.mr;
        if (m_ls_f) begin m_ls_d = h.data; m_ls_r = h.wreg; end
        m_fl = fl;
        if (fl) m_fl_pc = h.tgt;
        if (fl) begin
            mq.delete();
            m_tail = 0;
        end else begin
            if (com) void'(mq.pop_front());
            if (av && !frz && sz < ROB_DEPTH) begin
                e = '{tag: m_tail, wreg: bus.Alloc_writeRegister_IN, done: 0, rd: 0, mr: 0,
                      tk: 0, data: '0, tgt: '0};
                mq.push_back(e);
                m_tail = (m_tail + 1) % ROB_DEPTH;
            end
        end
        @(posedge CLK);
        @(negedge CLK);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        clr_in();
        #1;
        model_reset();
        check_all();
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        check_all();
    endtask

    task automatic alloc(input logic [5:0] wreg);
        clr_in();
        bus.Alloc_Valid_IN         = 1'b1;
        bus.Alloc_writeRegister_IN = wreg;
        bus.Alloc_PC_IN            = $urandom;
        cycle();
    endtask

    task automatic comp(input int tag, input logic [31:0] data, input bit rd, input bit mr,
                        input bit tk, input logic [31:0] tgt);
        clr_in();
        bus.Complete_Valid_IN       = 1'b1;
        bus.Complete_ROBPointer_IN  = 6'(tag);
        bus.Complete_Data_IN        = data;
        bus.Complete_RegDest_IN     = rd;
        bus.Complete_MemRead_IN     = mr;
        bus.Complete_Branch_flag_IN = tk;
        bus.Complete_target_PC_IN   = tgt;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            clr_in();
            cycle();
        end
    endtask

    initial begin
        int cand[$];
        int tag, kind;
        clr_in();
        model_reset();
        #1;
        check_all();
        @(negedge CLK);
        RESET = 1'b1;
        #1;

        // reset with entries held
        alloc(6'd1); alloc(6'd2); alloc(6'd3);
        @(negedge CLK);
        do_reset();

        // out-of-order completion, in-order commit
        alloc(6'd5); alloc(6'd6); alloc(6'd7);
        comp(2, 32'hA, 1, 0, 0, 0);
        comp(0, 32'hB, 1, 0, 0, 0);
        comp(1, 32'hC, 1, 0, 0, 0);
        idle(4);

        // load writeback
        do_reset();
        alloc(6'd9);
        comp(0, 32'hDEADBEEF, 0, 1, 0, 0);
        idle(3);

        // fill, overflow, wrap
        do_reset();
        for (int i = 0; i < ROB_DEPTH; i++) alloc(6'(i));
        alloc(6'd40);
        comp(0, 32'h1234, 1, 0, 0, 0);
        alloc(6'd41);
        alloc(6'd42);
        idle(1);

        // taken branch flush, allocation presented during flush is ignored
        do_reset();
        alloc(6'd3); alloc(6'd4);
        comp(1, 32'h55, 1, 0, 0, 0);
        comp(0, 32'h0, 0, 0, 1, 32'h00400100);
        alloc(6'd8);
        idle(3);

        // freeze holds a ready head
        do_reset();
        alloc(6'd12);
        comp(0, 32'h77, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            clr_in();
            FREEZE = 1'b1;
            bus.Alloc_Valid_IN = 1'b1;
            cycle();
        end
        idle(3);

        // completion to an invalid entry
        do_reset();
        comp(5, 32'h99, 1, 0, 0, 0);
        idle(2);

        // random traffic
        do_reset();
        for (int c = 0; c < 600; c++) begin
            clr_in();
            FREEZE                     = ($urandom_range(0, 9) == 0);
            bus.Alloc_Valid_IN         = ($urandom_range(0, 2) != 0);
            bus.Alloc_writeRegister_IN = 6'($urandom);
            bus.Alloc_PC_IN            = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                cand.delete();
                foreach (mq[i]) if (!mq[i].done) cand.push_back(mq[i].tag);
                if (cand.size() > 0 && $urandom_range(0, 7) != 0)
                    tag = cand[$urandom_range(0, cand.size() - 1)];
                else
                    tag = $urandom_range(0, ROB_DEPTH - 1);
                kind = $urandom_range(0, 39);
                bus.Complete_Valid_IN       = 1'b1;
                bus.Complete_ROBPointer_IN  = 6'(tag);
                bus.Complete_Data_IN        = $urandom;
                bus.Complete_RegDest_IN     = (kind < 20);
                bus.Complete_MemRead_IN     = (kind >= 20 && kind < 32);
                bus.Complete_Branch_flag_IN = (kind == 39);
                bus.Complete_target_PC_IN   = $urandom;
            end
            cycle();
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Reorder buffer and in-order commit stage; the consumer end of the execute stage's result interface.
- Allocates ROB tags at dispatch and accepts tagged completions from EXE.
- Retires one instruction per cycle from the head.
- Drives the COM forwarding/writeback buses (ALU and load) and the taken-branch/jump flush back into the pipeline.

Parameters:
- ROBWIDTH, 6, ROB tag width; depth = 2**ROBWIDTH = 64 entries.

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- FREEZE  in  1  stall; holds all state
- Alloc_Valid_IN  in  1  dispatch requests one entry this cycle
- Alloc_writeRegister_IN  in  6  destination register of the allocating instruction
- Alloc_PC_IN  in  32  PC of the allocating instruction
- ROBTail_OUT  out  ROBWIDTH  tag granted to the allocating instruction (current tail)
- ROB_Full_OUT  out  1  combinational, count == 64
- ROB_Empty_OUT  out  1  combinational, count == 0
- Complete_Valid_IN  in  1  EXE result valid
- Complete_ROBPointer_IN  in  ROBWIDTH  tag of the completing instruction
- Complete_Data_IN  in  32  ALU result or load data
- Complete_RegDest_IN  in  1  ALU writeback
- Complete_MemRead_IN  in  1  load writeback
- Complete_Branch_flag_IN  in  1  branch taken or jump
- Complete_target_PC_IN  in  32  redirect target
- fwd_data_1_COM  out  32  committed ALU data
- fwd_reg_1_COM  out  6  committed ALU register
- fwd_data_1_COM_flag  out  1  ALU commit strobe
- LS_fwd_data_COM  out  32  committed load data
- LS_fwd_reg_COM  out  6  committed load register
- LS_fwd_data_COM_flag  out  1  load commit strobe
- Flush_OUT  out  1  one-cycle redirect pulse
- Flush_PC_OUT  out  32  redirect target
- ROB_Error_OUT  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Per-entry state: valid, done, regdest, memread, taken, wreg[5:0], pc[31:0], data[31:0], target[31:0].
- Pointers: head and tail, ROBWIDTH bits each, wrap modulo 64. count is ROBWIDTH+1 bits.
- Reset (RESET low, asynchronous):
  - head, tail and count are 0; all valid/done bits are 0.
  - All flags and Flush_OUT are 0; all data/reg/PC outputs are 0.
  - Reset mid-operation discards all entries.
- Allocate: on a rising edge with Alloc_Valid_IN=1, !ROB_Full_OUT, !FREEZE and no flush this cycle:
  - entry[tail] gets valid=1, done=0, wreg, pc; tail increments.
  - ROBTail_OUT shows the pre-increment tail.
  - Allocation while full is dropped; dispatch must stall on ROB_Full_OUT.
- Complete: with Complete_Valid_IN=1, !FREEZE and no flush, entry[ptr] gets done=1 and records data, regdest, memread, taken and target.
  - Completion to an entry with valid=0 is ignored.
  - Completion to the head entry in the same cycle is visible for commit on the next cycle only (commit reads registered state).
- Commit: when entry[head] has valid&done and !FREEZE, at the clock edge:
  - regdest=1: fwd_data_1_COM/fwd_reg_1_COM are loaded and fwd_data_1_COM_flag=1 for one cycle.
  - memread=1: the LS_* bus is loaded and LS_fwd_data_COM_flag=1.
  - Neither set (stores, not-taken branches): no strobe.
  - The entry is cleared and head increments.
  - Commit latency: 1 cycle after done is set.
- Flush: when the committing entry has taken=1:
  - Flush_OUT=1 and Flush_PC_OUT=target for one cycle.
  - In the same edge, all valid/done bits are cleared and head=tail=count=0.
  - Allocation and completion presented that cycle are ignored.
- Simultaneous allocate and commit: count unchanged, both pointers advance.
- Full: a commit in the same cycle does not unblock allocation until the next cycle.
- Empty: no commit. Wrap: tail 63→0 and head 63→0 behave identically to other steps.
- FREEZE=1:
  - No allocate, complete, commit or flush.
  - Strobes and Flush_OUT are 0; data/reg outputs hold.
  - EXE holds its output during FREEZE, so completion is retaken after release.

Optional Feature:
- ROB_CHECK_EN defined: ROB_Error_OUT sets and stays set (until reset) on any of:
  - allocation while full;
  - completion to an invalid entry;
  - completion to an already-done entry;
  - Complete_RegDest_IN and Complete_MemRead_IN both 1.
  - Offending events are still handled as above.
- ROB_CHECK_EN undefined: ROB_Error_OUT is tied 0 and no check logic is present.

Decomposition:
- Package rob_pkg holds:
  - ROB_DEPTH constant;
  - rob_entry_t struct {valid, done, regdest, memread, taken, wreg, pc, data, target};
  - REG_WIDTH=6 constant.
- Sub-module rob_ptr_ctrl holds head/tail/count, full/empty, wrap and flush reset.
- The entry array and commit logic stay in rob_commit.

Test Plan:
- Reset with ROB holding 3 entries → ROB_Empty_OUT=1, all strobes 0, ROBTail_OUT=0.
- Allocate tags 0,1,2 (wreg 5,6,7); complete 2, then 0, then 1 with data 0xA,0xB,0xC, RegDest=1 → fwd strobes in order reg5=0xB, reg6=0xC, reg7=0xA, never out of order.
- Allocate tag 0 with load wreg 9; complete with MemRead=1, data 0xDEADBEEF → LS_fwd_data_COM_flag=1, LS_fwd_reg_COM=9, fwd_data_1_COM_flag stays 0.
- Allocate 64 → ROB_Full_OUT=1; a 65th allocation is dropped; commit one and allocate → tail wraps 63→0, count returns to 64.
- Tags 0 (branch, taken, target 0x00400100) and 1 (ALU) both done → at tag 0's commit, Flush_OUT=1, Flush_PC_OUT=0x00400100; tag 1 never commits; ROB_Empty_OUT=1 next cycle.
- Head done, FREEZE held 3 cycles → no strobe during freeze; a single strobe on the first cycle after release. With ROB_CHECK_EN, completing tag 5 when invalid → ROB_Error_OUT=1 and stays 1.
